// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID bypass,
// branch-flush bubbles and a saturating stall-event counter.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned NULL_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata_a,
    input  logic [DATA_W-1:0] id_rdata_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic [3:0]        id_aluop,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall_ifid,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic [3:0]        ex_aluop,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [REG_W-1:0] NULL_IDX = REG_W'(NULL_REG);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic              hazard;
    logic              load_bubble;
    logic              wb_hit_a;
    logic              wb_hit_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    // A load in EX whose result ID needs cannot be forwarded in time.
    assign hazard = id_valid & ex_valid & ex_memread & (ex_rd != NULL_IDX)
                  & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign stall_ifid = hazard & ~flush;

    // Same-cycle register-file write/read bypass.
    assign wb_hit_a = wb_regwrite & (wb_rd != NULL_IDX) & (wb_rd == id_rs);
    assign wb_hit_b = wb_regwrite & (wb_rd != NULL_IDX) & (wb_rd == id_rt);
    assign opnd_a   = wb_hit_a ? wb_data : id_rdata_a;
    assign opnd_b   = wb_hit_b ? wb_data : id_rdata_b;

    assign load_bubble = flush | hazard | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rs       <= NULL_IDX;
            ex_rt       <= NULL_IDX;
            ex_rd       <= NULL_IDX;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= '0;
        end else if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_rs       <= NULL_IDX;
            ex_rt       <= NULL_IDX;
            ex_rd       <= NULL_IDX;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_a        <= opnd_a;
            ex_b        <= opnd_b;
            ex_imm      <= id_imm;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_alusrc   <= id_alusrc;
            ex_aluop    <= id_aluop;
        end
    end

    // Saturating count of cycles in which IF/ID was actually held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_ifid && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and WB-to-ID bypass for the 8-bit pipelined core.
- Captures decoded operands and control from ID and presents EX_rs/EX_rt/EX_rd plus control to the EX stage and forwarding unit.
- Requests IF/ID stalls, inserts bubbles and honours branch flushes.
- Keeps a saturating stall-event counter for performance monitoring.

Parameters:
- DATA_W, 8, operand and immediate width.
- REG_W, 5, register index width.
- NULL_REG, 31, register index that is never written and never forwarded; used as the bubble destination.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_W each  decoded register indices.
- id_rdata_a, id_rdata_b  in  DATA_W each  register-file read data.
- id_imm  in  DATA_W  immediate.
- id_regwrite, id_memread, id_memwrite, id_alusrc  in  1 each  control bits.
- id_aluop  in  4  ALU operation.
- wb_regwrite  in  1  write-back enable.
- wb_rd  in  REG_W  write-back destination.
- wb_data  in  DATA_W  write-back data.
- flush  in  1  branch taken in EX; kill the ID instruction.
- stall_ifid  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  registered.
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered.
- ex_a, ex_b, ex_imm  out  DATA_W each  registered.
- ex_regwrite, ex_memread, ex_memwrite, ex_alusrc  out  1 each  registered.
- ex_aluop  out  4  registered.
- stall_count  out  CNT_W  registered.

Behaviour:
- Reset (async, rst_n=0):
  - ex_rs, ex_rt and ex_rd are all set to NULL_REG.
  - All other ex_* outputs go to 0.
  - stall_count goes to 0.
  - stall_ifid reads 0 while in reset.
- Load-use hazard (combinational):
  - hazard = id_valid & ex_valid & ex_memread & (ex_rd != NULL_REG) & ((ex_rd == id_rs) | (ex_rd == id_rt)).
  - stall_ifid = hazard & ~flush.
- Bypass: operand A = wb_data if wb_regwrite & (wb_rd != NULL_REG) & (wb_rd == id_rs), else id_rdata_a. Operand B is the same check against id_rt. This covers same-cycle register-file write/read.
- Register update on each rising clk edge, priority high to low:
  - 1. flush=1: load a bubble.
  - 2. hazard=1: load a bubble. The ID instruction is retained upstream and re-presented next cycle.
  - 3. Otherwise: capture the ID fields. ex_valid=id_valid. If id_valid=0, also force the bubble values.
- Bubble values: ex_valid=0; regwrite/memread/memwrite/alusrc=0; aluop=0; rs, rt and rd all set to NULL_REG; data fields=0. A bubble can never trigger forwarding or a hazard.
- Latency: 1 cycle ID→EX. A stalled instruction enters EX exactly 1 cycle later, and by then the load is in MEM so forwarding covers it. At most one stall cycle per load-use pair.
- stall_count:
  - Increments by 1 on each clock where stall_ifid=1.
  - Saturates at all-ones; no wrap.
  - Flush-suppressed hazards are not counted.
- Hazard and flush in the same cycle: flush wins, stall_ifid=0 and a bubble is loaded.
- id_rs/id_rt equal to NULL_REG never cause a hazard or a bypass.
- Reset asserted mid-stall: outputs clear immediately. The first post-reset cycle has no hazard because ex_memread=0.

Test Plan:
- Reset: pulse rst_n low → ex_rd=31, ex_regwrite=0, ex_valid=0, stall_count=0, stall_ifid=0.
- Normal flow: ID rs=2, rt=3, rd=4, rdata 0x11/0x22, regwrite=1 → next edge ex_a=0x11, ex_b=0x22, ex_rd=4, ex_regwrite=1, stall_ifid=0.
- Load-use: EX holds load rd=5 (memread=1); ID rs=5 →
  - stall_ifid=1;
  - next edge: bubble (ex_rd=31, ex_valid=0), stall_count=1;
  - re-presented instruction then captured with stall_ifid=0.
- Flush vs hazard: same load-use setup with flush=1 → stall_ifid=0, bubble loaded, stall_count unchanged.
- WB bypass: wb_regwrite=1, wb_rd=7, wb_data=0xA5; ID rt=7 with stale rdata_b=0x00 → ex_b=0xA5. Repeat with wb_rd=31 → ex_b=0x00.
- Saturation: preload via 2^CNT_W−1 consecutive stalls (or a CNT_W=4 build: 15 stalls) → stall_count holds all-ones after further stalls.
